// File: rtl/seg_scroller_if.sv
// Signal bundle between the scroller and its controller: message write port, scroll controls
// and the registered window outputs.
interface seg_scroller_if #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned MSG_LEN    = 16,
   parameter int unsigned AW         = $clog2(MSG_LEN)
);
   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic [3:0]              wr_data;
   logic                    run;
   logic                    dir;
   logic                    step;
   logic [4*NUM_DIGITS-1:0] digits;
   logic [AW-1:0]           ptr;
   logic                    shift_pulse;

   modport master (
      output wr_en, wr_addr, wr_data, run, dir, step,
      input  digits, ptr, shift_pulse
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, run, dir, step,
      output digits, ptr, shift_pulse
   );
endinterface

// File: rtl/seg_scroller.sv
// Circular nibble message with a NUM_DIGITS-wide scrolling window for seven-segment decoders.
// The window scrolls on a prescaled tick while running, or on a manual step while paused.
module seg_scroller #(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned MSG_LEN    = 16,
   parameter int unsigned TICK_DIV   = 25000000,
   localparam int unsigned AW        = $clog2(MSG_LEN)
) (
   input logic           clk,
   input logic           rst_n,
   seg_scroller_if.slave ctrl
);
   localparam int unsigned   CW     = $clog2(TICK_DIV);
   localparam logic [AW:0]   LenW   = (AW+1)'(MSG_LEN);
   localparam logic [AW-1:0] LastW  = AW'(MSG_LEN - 1);
   localparam logic [CW-1:0] CntTop = CW'(TICK_DIV - 1);

   logic [3:0]              mem_q [MSG_LEN];
   logic [AW-1:0]           ptr_q, ptr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic                    pulse_q;
   logic                    tick, shift, wr_hit;

   // Sum is one bit wider than a pointer, so a single conditional subtract is an exact modulo.
   function automatic logic [AW-1:0] wrap_idx(input logic [AW-1:0] base, input int unsigned off);
      logic [AW:0] sum;
      sum = {1'b0, base} + (AW+1)'(off);
      if (sum >= LenW) sum = sum - LenW;
      return sum[AW-1:0];
   endfunction

   function automatic logic [4*NUM_DIGITS-1:0] reset_image();
      logic [4*NUM_DIGITS-1:0] img;
      img = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         img[4*d +: 4] = 4'(((NUM_DIGITS - 1 - d) % MSG_LEN) % 16);
      end
      return img;
   endfunction

   always_comb begin
      tick   = ctrl.run && (cnt_q == CntTop);
      shift  = ctrl.run ? tick : ctrl.step;
      wr_hit = ctrl.wr_en && ({1'b0, ctrl.wr_addr} < LenW);

      // Pausing freezes the prescaler so resuming continues the interrupted period.
      cnt_d = cnt_q;
      if (ctrl.run) cnt_d = tick ? '0 : cnt_q + CW'(1);

      ptr_d = ptr_q;
      if (shift) begin
         if (!ctrl.dir) ptr_d = (ptr_q == LastW) ? '0 : ptr_q + AW'(1);
         else           ptr_d = (ptr_q == '0) ? LastW : ptr_q - AW'(1);
      end
   end

   always_comb begin
      digits_d = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         digits_d[4*d +: 4] = mem_q[wrap_idx(ptr_q, NUM_DIGITS - 1 - d)];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < MSG_LEN; k++) mem_q[k] <= 4'(k % 16);
      end else if (wr_hit) begin
         mem_q[ctrl.wr_addr] <= ctrl.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         cnt_q    <= '0;
         pulse_q  <= 1'b0;
         digits_q <= reset_image();
      end else begin
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         pulse_q  <= shift;
         digits_q <= digits_d;
      end
   end

   assign ctrl.digits      = digits_q;
   assign ctrl.ptr         = ptr_q;
   assign ctrl.shift_pulse = pulse_q;
endmodule

// File: tb/tb_seg_scroller.sv
// Self-checking bench for seg_scroller: directed scenarios plus random traffic compared
// against an array-based model of the message, window and prescaler.
module tb_seg_scroller;
   localparam int NUM_DIGITS = 6;
   localparam int MSG_LEN    = 16;
   localparam int TICK_DIV   = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   seg_scroller_if #(.NUM_DIGITS(NUM_DIGITS), .MSG_LEN(MSG_LEN)) bus ();

   seg_scroller #(
      .NUM_DIGITS(NUM_DIGITS),
      .MSG_LEN   (MSG_LEN),
      .TICK_DIV  (TICK_DIV)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ctrl (bus.slave)
   );

   always #5 clk = ~clk;

   int          mm [MSG_LEN];
   int          mptr;
   int          mcnt;
   logic [23:0] exp_dig;
   logic        exp_pulse;
   int          npulse;

   function automatic logic [23:0] win();
      logic [23:0] r;
      for (int d = 0; d < NUM_DIGITS; d++) r[4*d +: 4] = 4'(mm[(mptr + NUM_DIGITS - 1 - d) % MSG_LEN]);
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < MSG_LEN; k++) mm[k] = k % 16;
      mptr      = 0;
      mcnt      = 0;
      exp_dig   = win();
      exp_pulse = 1'b0;
   endtask

   task automatic model_edge();
      bit tk, sh;
      tk      = bus.run && (mcnt == TICK_DIV - 1);
      sh      = bus.run ? tk : bus.step;
      exp_dig = win();
      if (bus.run) mcnt = tk ? 0 : mcnt + 1;
      if (sh) mptr = bus.dir ? (mptr + MSG_LEN - 1) % MSG_LEN : (mptr + 1) % MSG_LEN;
      if (bus.wr_en && int'(bus.wr_addr) < MSG_LEN) mm[bus.wr_addr] = int'(bus.wr_data);
      exp_pulse = sh;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      chk("digits", 32'(bus.digits), 32'(exp_dig));
      chk("ptr", 32'(bus.ptr), 32'(mptr));
      chk("shift_pulse", 32'(bus.shift_pulse), 32'(exp_pulse));
      if (bus.shift_pulse) npulse++;
   endtask

   task automatic do_step();
      bus.step = 1'b1;
      cycle();
      bus.step = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      chk("rst_digits", 32'(bus.digits), 32'h012345);
      chk("rst_ptr", 32'(bus.ptr), 32'd0);
      chk("rst_pulse", 32'(bus.shift_pulse), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      npulse      = 0;
      clk         = 1'b0;
      rst_n       = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.run     = 1'b0;
      bus.dir     = 1'b0;
      bus.step    = 1'b0;
      model_reset();
      #12;
      rst_n = 1'b1;
      chk("init_digits", 32'(bus.digits), 32'h012345);
      chk("init_ptr", 32'(bus.ptr), 32'd0);

      // Paused: nothing moves.
      for (int i = 0; i < 20; i++) cycle();
      chk("idle_pulses", 32'(npulse), 32'd0);
      chk("idle_digits", 32'(bus.digits), 32'h012345);

      // Auto-scroll left: ticks on edges 4, 8, 12.
      bus.run = 1'b1;
      for (int i = 0; i < 13; i++) cycle();
      chk("run_pulses", 32'(npulse), 32'd3);
      chk("run_ptr", 32'(bus.ptr), 32'd3);
      chk("run_digits", 32'(bus.digits), 32'h345678);
      bus.run = 1'b0;

      // Left wrap via manual steps.
      for (int i = 0; i < 11; i++) do_step();
      chk("ptr14", 32'(bus.ptr), 32'd14);
      do_step();
      chk("ptr15", 32'(bus.ptr), 32'd15);
      cycle();
      chk("wrap_digits", 32'(bus.digits), 32'hF01234);
      do_step();
      chk("ptr_wrap0", 32'(bus.ptr), 32'd0);

      // Right wrap, then step held during run must be ignored.
      bus.dir = 1'b1;
      do_step();
      chk("ptr_rwrap", 32'(bus.ptr), 32'd15);
      npulse   = 0;
      bus.run  = 1'b1;
      bus.step = 1'b1;
      for (int i = 0; i < 8; i++) cycle();
      chk("held_step_pulses", 32'(npulse), 32'd2);
      chk("held_step_ptr", 32'(bus.ptr), 32'd13);
      bus.run  = 1'b0;
      bus.step = 1'b0;
      bus.dir  = 1'b0;

      // Write coinciding with a shift.
      do_reset();
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd2;
      bus.wr_data = 4'hA;
      bus.step    = 1'b1;
      cycle();
      bus.wr_en = 1'b0;
      bus.step  = 1'b0;
      chk("wr_shift_ptr", 32'(bus.ptr), 32'd1);
      cycle();
      chk("wr_shift_digits", 32'(bus.digits), 32'h1A3456);

      // Pause at count 2, resume: tick two edges later.
      do_reset();
      bus.run = 1'b1;
      cycle();
      cycle();
      bus.run = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      bus.run = 1'b1;
      cycle();
      chk("resume_no_pulse", 32'(bus.shift_pulse), 32'd0);
      cycle();
      chk("resume_pulse", 32'(bus.shift_pulse), 32'd1);
      for (int i = 0; i < 5; i++) cycle();
      do_reset();

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         bus.wr_en   = 1'($urandom_range(0, 1));
         bus.wr_addr = 4'($urandom_range(0, MSG_LEN - 1));
         bus.wr_data = 4'($urandom);
         bus.run     = ($urandom_range(0, 3) != 0);
         bus.dir     = 1'($urandom_range(0, 1));
         bus.step    = 1'($urandom_range(0, 1));
         cycle();
      end

      // Reset pulsed mid-run, then continue.
      bus.run   = 1'b1;
      bus.wr_en = 1'b0;
      cycle();
      do_reset();
      for (int i = 0; i < 10; i++) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scroller.md
Name: seg_scroller

Overview:
Upstream feeder for a bank of hex-to-seven-segment decoders. Holds a writable circular message of 4-bit nibbles and presents a NUM_DIGITS-wide window of that message. The window scrolls one position per prescaled tick, or on a single-step command. Each 4-bit slice of `digits` drives one decoder instance, which maps 0..F to active-low segments.

Parameters:
- NUM_DIGITS, 6: number of display digits driven.
- MSG_LEN, 16: message buffer depth in nibbles. Legal when MSG_LEN >= NUM_DIGITS and MSG_LEN >= 2.
- TICK_DIV, 25000000: clock cycles per automatic scroll step. Must be >= 2.
- AW, $clog2(MSG_LEN): address and pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe for the message buffer.
- wr_addr  in  AW  write address. Ignored if >= MSG_LEN.
- wr_data  in  4  nibble to write.
- run  in  1  1 = auto-scroll enabled; 0 = paused.
- dir  in  1  0 = scroll left (ptr increments); 1 = scroll right (ptr decrements).
- step  in  1  single-cycle manual step request. Honoured only when run=0.
- digits  out  4*NUM_DIGITS  registered nibbles. Slice [4d+3:4d] feeds digit d; digit NUM_DIGITS-1 is leftmost.
- ptr  out  AW  current window start index, registered.
- shift_pulse  out  1  1-cycle pulse, asserted in the cycle after ptr changed.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - mem[k] = k mod 16.
  - ptr = 0.
  - Prescaler count = 0.
  - shift_pulse = 0.
  - digits = reset image of the window. With defaults this is 24'h012345.
- Window mapping:
  - digits slice d = mem[(ptr + NUM_DIGITS-1-d) mod MSG_LEN], registered every clock.
  - Leftmost digit shows mem[ptr].
- Prescaler:
  - When run=1, count increments each cycle.
  - At count == TICK_DIV-1, `tick` asserts for that cycle and count returns to 0.
  - When run=0, count holds its value; it is not cleared.
  - Deasserting and reasserting run resumes from the held count.
- Shift event: `shift = (run & tick) | (~run & step)`. At most one shift per cycle.
  - step while run=1 is ignored.
- Pointer update on shift:
  - dir=0: ptr = (ptr == MSG_LEN-1) ? 0 : ptr+1.
  - dir=1: ptr = (ptr == 0) ? MSG_LEN-1 : ptr-1.
  - Wrap is explicit, so non-power-of-2 MSG_LEN is valid.
- Write:
  - If wr_en=1 and wr_addr < MSG_LEN, then mem[wr_addr] <= wr_data at the clock edge.
  - Writes are independent of run, step and shift, and may coincide with a shift. Both take effect at the same edge.
- Latency:
  - A write or shift at edge N appears on `digits` at edge N+1.
  - shift_pulse is high during the cycle following edge N; it is aligned with the updated ptr and precedes the digits update by one cycle.
- Reset asserted mid-scroll: all state returns to reset values immediately. Any pending step or tick is discarded.
- No bus handshake: the write port is always ready and there is no back-pressure.
- Arithmetic width: index sums use AW+1 bits before modulo reduction, with no truncation error for any ptr.
- Out-of-range wr_addr (possible when MSG_LEN is not a power of 2) is dropped silently.

Test Plan:
1. Reset release, TICK_DIV=4, run=0: digits == 24'h012345 and ptr == 0. The outputs hold for 20 cycles with no shift_pulse.
2. run=1, dir=0, TICK_DIV=4: shift_pulse every 4th cycle. After 3 shifts, ptr == 3 and digits == 24'h345678.
3. Left-wrap: from ptr=14, dir=0, step twice with run=0. ptr goes to 15 then 0. At ptr=15, digits == 24'hF01234.
4. Right-wrap: from ptr=0, dir=1, one step gives ptr == 15. step held high while run=1 produces no extra shifts beyond the ticks.
5. Write 4'hA to addr 2 in the same cycle as a left shift from ptr=0. ptr=1 and digits == 24'h1A3456 one cycle later.
6. Set run=0 at count 2, hold 10 cycles, then set run=1. The next shift_pulse occurs 2 cycles later. Pulsing rst_n low mid-run restores digits == 24'h012345 asynchronously.
